// File: rtl/chaotic_pkg.sv
// Shared defaults and the FSM state encoding for the chaotic-iteration controller.
package chaotic_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TIMEOUT_DEF    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;
endpackage

// File: rtl/chaotic_watchdog.sv
// Cycle watchdog for one datapath round trip; expired is high in the TIMEOUT-th enabled cycle.
module chaotic_watchdog
  import chaotic_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  assign expired = enable && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (clear)              cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/chaotic_iter_ctrl.sv
// Sequencer for an external chaotic-equations datapath: seeds it, drops transient
// iterations, then streams samples with backpressure, stop and timeout handling.
module chaotic_iter_ctrl
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] y0,
  input  logic [DATA_WIDTH-1:0] z0,
  input  logic [CNT_WIDTH-1:0]  discard,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  eq_n_valid,
  output logic [DATA_WIDTH-1:0] eq_xn,
  output logic [DATA_WIDTH-1:0] eq_yn,
  output logic [DATA_WIDTH-1:0] eq_zn,
  input  logic                  eq_n1_valid,
  input  logic [DATA_WIDTH-1:0] eq_xn1,
  input  logic [DATA_WIDTH-1:0] eq_yn1,
  input  logic [DATA_WIDTH-1:0] eq_zn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  state_e                state_q;
  logic [DATA_WIDTH-1:0] x_q, y_q, z_q, ox_q, oy_q, oz_q;
  logic [CNT_WIDTH-1:0]  disc_q, count_q, iter_q, emit_q;
  logic [CNT_WIDTH-1:0]  iter_d, emit_d;
  logic                  warm_q, stop_pend_q, out_valid_q, done_q, tmo_q;
  logic                  stop_req, last_emit, wd_expired;

  assign iter_d    = iter_q + 1'b1;
  assign emit_d    = emit_q + 1'b1;
  assign stop_req  = stop_pend_q | stop;
  assign last_emit = (count_q != '0) && (emit_d == count_q);

  assign busy        = (state_q != ST_IDLE);
  assign eq_n_valid  = (state_q == ST_ISSUE);
  assign eq_xn       = x_q;
  assign eq_yn       = y_q;
  assign eq_zn       = z_q;
  assign out_valid   = out_valid_q;
  assign out_x       = ox_q;
  assign out_y       = oy_q;
  assign out_z       = oz_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;

  chaotic_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_ISSUE),
    .enable (state_q == ST_WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      {x_q, y_q, z_q, ox_q, oy_q, oz_q} <= '0;
      {disc_q, count_q, iter_q, emit_q} <= '0;
      warm_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy && stop) stop_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (start) begin
          x_q <= x0; y_q <= y0; z_q <= z0;
          disc_q      <= discard;
          count_q     <= count;
          iter_q      <= '0;
          emit_q      <= '0;
          warm_q      <= 1'b0;
          stop_pend_q <= 1'b0;
          tmo_q       <= 1'b0;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (eq_n1_valid) begin
            x_q <= eq_xn1; y_q <= eq_yn1; z_q <= eq_zn1;
            iter_q <= iter_d;
            // warm_q keeps a wrapped iteration counter from re-entering the transient phase
            if (!warm_q && iter_d <= disc_q) begin
              state_q <= stop_req ? ST_IDLE : ST_ISSUE;
              done_q  <= stop_req;
            end else begin
              warm_q      <= 1'b1;
              ox_q <= eq_xn1; oy_q <= eq_yn1; oz_q <= eq_zn1;
              out_valid_q <= 1'b1;
              state_q     <= ST_EMIT;
            end
          end else if (wd_expired) begin
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_EMIT: if (out_ready) begin
          emit_q      <= emit_d;
          out_valid_q <= 1'b0;
          if (last_emit || stop_req) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chaotic_iter_ctrl.sv
// Scoreboard bench: expected samples are seed + discard + k per lane, checked on each handshake.
module tb_chaotic_iter_ctrl;
  localparam int DW  = 64;
  localparam int CW  = 32;
  localparam int TMO = 64;
  localparam int LAT = 10;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [DW-1:0] x0 = '0, y0 = '0, z0 = '0;
  logic [CW-1:0] discard = '0, count = '0;
  logic          eq_n_valid;
  logic [DW-1:0] eq_xn, eq_yn, eq_zn;
  logic          eq_n1_valid = 1'b0;
  logic [DW-1:0] eq_xn1 = '0, eq_yn1 = '0, eq_zn1 = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_x, out_y, out_z;
  logic          busy, done, timeout_err;

  always #5 clk = ~clk;

  chaotic_iter_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .x0(x0), .y0(y0), .z0(z0), .discard(discard), .count(count),
    .eq_n_valid(eq_n_valid), .eq_xn(eq_xn), .eq_yn(eq_yn), .eq_zn(eq_zn),
    .eq_n1_valid(eq_n1_valid), .eq_xn1(eq_xn1), .eq_yn1(eq_yn1), .eq_zn1(eq_zn1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  typedef struct {real x; real y; real z;} smp_t;
  smp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int n_issue = 0, n_done = 0, n_emit = 0;
  bit stub_en = 1'b1, rdy_rand = 1'b0;

  task automatic check(input string name, input bit ok, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  function automatic string b2s(input logic v);
    return $sformatf("%0b", v);
  endfunction

  // Stub datapath: latency LAT, returns state + 1.0 in each lane.
  initial begin
    bit  pend = 1'b0;
    int  sc = 0;
    real sx = 0.0, sy = 0.0, sz = 0.0;
    forever begin
      @(posedge clk); #1;
      eq_n1_valid = 1'b0;
      if (pend) begin
        sc--;
        if (sc == 0) begin
          pend = 1'b0;
          if (stub_en) begin
            eq_n1_valid = 1'b1;
            eq_xn1 = $realtobits(sx); eq_yn1 = $realtobits(sy); eq_zn1 = $realtobits(sz);
          end
        end
      end
      if (eq_n_valid) begin
        pend = 1'b1; sc = LAT;
        sx = $bitstoreal(eq_xn) + 1.0; sy = $bitstoreal(eq_yn) + 1.0; sz = $bitstoreal(eq_zn) + 1.0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every accepted sample.
  always @(negedge clk) begin
    smp_t e;
    real ax, ay, az;
    if (eq_n_valid) n_issue++;
    if (done) n_done++;
    if (out_valid && out_ready) begin
      n_emit++;
      ax = $bitstoreal(out_x); ay = $bitstoreal(out_y); az = $bitstoreal(out_z);
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 1'b0, $sformatf("%0.1f/%0.1f/%0.1f", ax, ay, az), "no sample");
      end else begin
        e = exp_q.pop_front();
        check("sample", ax == e.x && ay == e.y && az == e.z,
              $sformatf("%0.1f/%0.1f/%0.1f", ax, ay, az),
              $sformatf("%0.1f/%0.1f/%0.1f", e.x, e.y, e.z));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_exp(input real sx, input real sy, input real sz, input int d, input int c);
    smp_t e;
    for (int k = 1; k <= c; k++) begin
      e.x = sx + d + k; e.y = sy + d + k; e.z = sz + d + k;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run(input real sx, input real sy, input real sz, input int d, input int c);
    x0 = $realtobits(sx); y0 = $realtobits(sy); z0 = $realtobits(sz);
    discard = CW'(d); count = CW'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin tick(); i++; end
    check(name, !busy, b2s(busy), "busy=0 within budget");
  endtask

  function automatic bit outs_zero();
    return !eq_n_valid && eq_xn == '0 && eq_yn == '0 && eq_zn == '0 && !out_valid &&
           out_x == '0 && out_y == '0 && out_z == '0 && !busy && !done && !timeout_err;
  endfunction

  task automatic end_run(input string name, input int done0);
    tick(2);
    check({name, "_done"}, n_done == done0 + 1, $sformatf("%0d", n_done - done0), "1");
    check({name, "_drained"}, exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
  endtask

  initial begin
    int d0, i0, e0, got, i;
    bit ok;
    real s, cx, cy, cz;

    tick(2);
    check("reset_outputs", outs_zero(), "nonzero output", "all zero");
    rst_n = 1'b1;
    tick(2);
    check("idle_after_reset", outs_zero(), "nonzero output", "all zero");

    // stop and late start handling in IDLE: stop alone must not launch
    stop = 1'b1; tick(); stop = 1'b0; tick();
    check("stop_in_idle", !busy, b2s(busy), "0");

    // Reference run: seed 1.0, discard 2, count 3 -> 4,5,6
    out_ready = 1'b1;
    d0 = n_done; e0 = n_emit;
    push_exp(1.0, 1.0, 1.0, 2, 3);
    stop = 1'b1;
    start_run(1.0, 1.0, 1.0, 2, 3);
    stop = 1'b0;
    check("issue_latency", eq_n_valid === 1'b1, b2s(eq_n_valid), "1");
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("ref_idle", 500);
    end_run("ref", d0);
    check("ref_count", n_emit - e0 == 3, $sformatf("%0d", n_emit - e0), "3");

    // Randomized runs with random backpressure
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int dd, cc;
      real a, b, c;
      a = $urandom_range(0, 1000); b = $urandom_range(0, 1000); c = $urandom_range(0, 1000);
      dd = $urandom_range(0, 3); cc = $urandom_range(1, 4);
      d0 = n_done;
      push_exp(a, b, c, dd, cc);
      start_run(a, b, c, dd, cc);
      wait_idle("rand_idle", 1000);
      end_run("rand", d0);
    end
    rdy_rand = 1'b0;

    // Backpressure: hold out_ready low 20 cycles in EMIT
    out_ready = 1'b0;
    d0 = n_done;
    push_exp(10.0, 20.0, 30.0, 0, 2);
    start_run(10.0, 20.0, 30.0, 0, 2);
    i = 0;
    while (!out_valid && i < 100) begin tick(); i++; end
    check("bp_valid_rises", out_valid, b2s(out_valid), "1");
    cx = $bitstoreal(out_x); cy = $bitstoreal(out_y); cz = $bitstoreal(out_z);
    i0 = n_issue; ok = 1'b1;
    repeat (20) begin
      tick();
      if (!out_valid || $bitstoreal(out_x) != cx || $bitstoreal(out_y) != cy ||
          $bitstoreal(out_z) != cz || eq_n_valid) ok = 1'b0;
    end
    check("bp_hold_stable", ok && n_issue == i0, b2s(ok), "stable, no issue");
    out_ready = 1'b1;
    tick();
    check("bp_ready_to_issue", eq_n_valid === 1'b1, b2s(eq_n_valid), "1");
    wait_idle("bp_idle", 500);
    end_run("bp", d0);

    // Timeout with a silent datapath
    stub_en = 1'b0;
    d0 = n_done;
    start_run(1.0, 1.0, 1.0, 0, 1);
    tick(64);
    check("tmo_not_early", busy && !timeout_err, b2s(busy), "busy=1 err=0");
    tick();
    check("tmo_busy", !busy, b2s(busy), "0");
    check("tmo_flag", timeout_err, b2s(timeout_err), "1");
    tick(2);
    check("tmo_no_done", n_done == d0, $sformatf("%0d", n_done - d0), "0");
    stub_en = 1'b1;
    d0 = n_done;
    push_exp(2.0, 2.0, 2.0, 0, 1);
    start_run(2.0, 2.0, 2.0, 0, 1);
    check("tmo_cleared", !timeout_err, b2s(timeout_err), "0");
    wait_idle("tmo_rerun_idle", 500);
    end_run("tmo_rerun", d0);

    // Stop during WAIT in free-run: one sample, then done
    d0 = n_done; i0 = n_issue;
    push_exp(5.0, 5.0, 5.0, 0, 1);
    start_run(5.0, 5.0, 5.0, 0, 0);
    tick(3);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("stop_idle", 500);
    end_run("stop", d0);
    tick(20);
    check("stop_no_reissue", n_issue == i0 + 1, $sformatf("%0d", n_issue - i0), "1");

    // Reset mid-WAIT, then a late datapath response
    i0 = n_issue; e0 = n_emit;
    start_run(7.0, 7.0, 7.0, 0, 1);
    tick(3);
    rst_n = 1'b0;
    tick(2);
    check("midreset_outputs", outs_zero(), "nonzero output", "all zero");
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin tick(); if (!outs_zero()) ok = 1'b0; end
    check("late_result_ignored", ok && n_emit == e0 && n_issue == i0 + 1, b2s(ok), "idle, all zero");

    // Free-run 1000 samples then stop
    rdy_rand = 1'b1;
    s = $urandom_range(0, 500);
    d0 = n_done; e0 = n_emit;
    push_exp(s, s + 1.0, s + 2.0, 0, 1001);
    start_run(s, s + 1.0, s + 2.0, 0, 0);
    i = 0;
    while (n_emit - e0 < 1000 && i < 40000) begin tick(); i++; end
    check("free_reach_1000", n_emit - e0 >= 1000, $sformatf("%0d", n_emit - e0), ">=1000");
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle("free_idle", 500);
    tick(2);
    rdy_rand = 1'b0;
    got = n_emit - e0;
    check("free_count", got == 1000 || got == 1001, $sformatf("%0d", got), "1000 or 1001");
    check("free_done", n_done == d0 + 1, $sformatf("%0d", n_done - d0), "1");
    check("free_leftover", exp_q.size() == 1001 - got, $sformatf("%0d", exp_q.size()),
          $sformatf("%0d", 1001 - got));
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/chaotic_iter_ctrl.md
CHAOTIC_ITER_CTRL -- requirements
Module: chaotic_iter_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 64, floating-point word width; SHALL match the chaotic-equations datapath.
- CNT_WIDTH, 32, width of the iteration counters.
- TIMEOUT, 1024, maximum cycles to wait for a datapath result.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, begin a run; sampled only in IDLE.
- stop, in, 1, request early termination; sampled only while busy.
- x0/y0/z0, in, DATA_WIDTH each, seed state.
- discard, in, CNT_WIDTH, number of transient iterations to drop.
- count, in, CNT_WIDTH, number of samples to emit; 0 means free-run.
- eq_n_valid, out, 1, one-cycle issue strobe to the datapath.
- eq_xn/eq_yn/eq_zn, out, DATA_WIDTH each, current state to the datapath.
- eq_n1_valid, in, 1, datapath result valid.
- eq_xn1/eq_yn1/eq_zn1, in, DATA_WIDTH each, next state from the datapath.
- out_valid, out, 1, sample valid.
- out_ready, in, 1, sample accepted.
- out_x/out_y/out_z, out, DATA_WIDTH each, emitted sample.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle pulse at the end of a run.
- timeout_err, out, 1, sticky datapath-timeout flag.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, EMIT; busy is 1 in every state except IDLE.
REQ-004 IDLE with start=1: latch x0/y0/z0 into the state registers, latch discard and count, clear the iteration and emit counters and timeout_err, then go to ISSUE.
REQ-005 ISSUE: eq_n_valid=1 for exactly one cycle, clear the watchdog, go to WAIT; eq_xn/yn/zn SHALL equal the state registers and stay stable through WAIT.
REQ-006 WAIT with eq_n1_valid=1: load eq_xn1/yn1/zn1 into the state registers and increment the iteration counter. If the iteration count is still at or below discard, go to ISSUE. Otherwise copy the result to out_x/y/z, set out_valid=1 on the next cycle, and go to EMIT.
REQ-007 WAIT: the watchdog SHALL count cycles. On reaching TIMEOUT without eq_n1_valid, go to IDLE with timeout_err=1 and done=0.
REQ-008 EMIT: out_valid and out_x/y/z SHALL be held until out_ready=1. No eq_n_valid is issued while in EMIT.
REQ-009 EMIT on the handshake: increment the emit counter and drop out_valid. If count≠0 and the emit counter equals count, go to IDLE with a done pulse; else go to ISSUE.
REQ-010 stop=1 while busy SHALL set a stop_pending flag. Whenever the FSM would next enter ISSUE, it goes to IDLE instead with a done pulse. An in-flight result is still absorbed and, if due, emitted first.
REQ-011 start while busy SHALL be ignored. stop in IDLE SHALL be ignored. If start and stop are both 1 in IDLE, start wins.
REQ-012 eq_n1_valid outside WAIT SHALL be ignored.
REQ-013 Latency: eq_n_valid rises 1 cycle after start is sampled. out_valid rises 1 cycle after the qualifying eq_n1_valid.
REQ-014 The iteration and emit counters SHALL wrap modulo 2^CNT_WIDTH in free-run. Wrap SHALL NOT terminate a free-run.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE and clear the state registers, counters, stop_pending and watchdog. All outputs SHALL be 0: eq_n_valid, eq_x/y/zn, out_valid, out_x/y/z, busy, done, timeout_err.
REQ-016 A reset mid-run SHALL abandon the run. A late eq_n1_valid after reset SHALL be ignored.

Structure
REQ-017 Package chaotic_pkg SHALL hold the FSM state encoding, the DATA_WIDTH default and the TIMEOUT default.
REQ-018 The watchdog SHALL be one sub-module, chaotic_watchdog, with inputs clear and enable and output expired.

Verification
REQ-019 Use a stub datapath with latency 10 returning the state plus 1.0 in each lane. Seed 1.0, discard=2, count=3 -> samples 4.0, 5.0, 6.0 in each lane, then a single done pulse, then busy=0.
REQ-020 Hold out_ready=0 for 20 cycles in EMIT -> out_valid and data stay constant and there is no eq_n_valid. out_ready=1 -> the next eq_n_valid follows 1 cycle later.
REQ-021 TIMEOUT=64 with a stub that never responds -> 64 cycles after the ISSUE cycle, timeout_err=1 and busy=0. The next start clears timeout_err.
REQ-022 Pulse stop during WAIT with count=0 -> the pending result is emitted, then IDLE with a done pulse and no further eq_n_valid.
REQ-023 Assert rst_n=0 mid-WAIT, release it, then fire the stub eq_n1_valid -> all outputs remain 0 and the FSM stays in IDLE.
REQ-024 Free-run with count=0 and discard=0 for 1000 samples, then stop -> exactly 1000 or 1001 samples, each equal to its predecessor plus 1.0.
